mul_wb_scheduler: RTL and testbench
===================================

Name: mul_wb_scheduler

Overview:
- Shares the single regfile write port between the main pipeline WB stage and the 5-stage MUL pipeline output (WMUL).
- Buffers MUL results that lose arbitration in a small FIFO.
- Tracks in-flight MUL destinations in a scoreboard and raises the ID-stage RAW/WAW hazard stall.
- Sits beside the regfile, feeding the pipeline control unit's ID and MUL_M* stall logic.

Parameters:
- QDEPTH, 2, MUL result queue entries (>=1)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-low reset
- wb_valid_i  in  1  WB stage holds a valid instruction
- wb_we_i  in  1  WB instruction writes the regfile
- wb_rd_i  in  5  WB destination register
- wb_data_i  in  32  WB write data
- wmul_valid_i  in  1  MUL result valid at WMUL
- wmul_rd_i  in  5  MUL destination register
- wmul_data_i  in  32  MUL result
- id_valid_i  in  1  ID holds a valid instruction
- id_advance_i  in  1  ID instruction moves on this cycle (already qualified by !hazard_stall_o)
- id_is_mul_i  in  1  ID instruction is a MUL
- id_reads_rs1_i, id_reads_rs2_i  in  1 each  ID instruction reads rs1 / rs2
- id_rs1_i, id_rs2_i  in  5 each  ID source registers
- id_writes_rd_i  in  1  ID instruction writes rd
- id_rd_i  in  5  ID destination register
- rf_we_o  out  1  regfile write enable
- rf_wr_addr_o  out  5  regfile write address
- rf_wr_data_o  out  32  regfile write data
- mul_stall_o  out  1  stall all MUL_M* stage registers
- hazard_stall_o  out  1  stall PC/ID due to pending MUL destination

Behaviour:
Reset (reset_i low at a rising edge):
- scoreboard pending[31:0]=0, queue empty, count=0.
- While reset_i is low: rf_we_o=0, mul_stall_o=0, hazard_stall_o=0.

Port arbitration (combinational, same cycle):
- wb_req = wb_valid_i & wb_we_i & (wb_rd_i!=0).
- mul_in = wmul_valid_i & !mul_stall_o.
- Priority 1: wb_req -> port driven by WB. If mul_in, the result is pushed to the queue.
- Priority 2: queue non-empty -> pop head to port. If mul_in, push in the same cycle (count unchanged).
- Priority 3: mul_in with queue empty -> WMUL written directly, zero latency.
- Otherwise rf_we_o=0.
- MUL results always retire in issue order; the direct path is used only when the queue is empty.
- wmul_rd_i==0: accepted and dropped, never written, never queued.

Queue:
- Circular FIFO, QDEPTH entries of {rd, data}; read/write pointers wrap modulo QDEPTH.
- mul_stall_o = (count==QDEPTH), from the registered count. While full, WMUL is held and a pop still occurs if WB is idle.
- No overflow or underflow is possible.

Scoreboard:
- Set: pending[id_rd_i] <= 1 when id_valid_i & id_advance_i & id_is_mul_i & id_writes_rd_i & id_rd_i!=0.
- Clear: pending[rd] <= 0 when a MUL result for rd is written on the port, via pop or direct path.
- Set and clear of the same rd in one cycle cannot occur, because WAW stalls issue. If it did, set wins.
- hazard_stall_o = id_valid_i & ( (id_reads_rs1_i & rs1!=0 & pending[rs1]) | (id_reads_rs2_i & rs2!=0 & pending[rs2]) | (id_writes_rd_i & rd!=0 & pending[rd]) ).
- hazard_stall_o is computed from registered pending only, so a register clearing this cycle still stalls ID for that cycle.
- MUL pipeline entries are non-speculative. Flushes never affect the scoreboard or the queue.
- Reset mid-operation discards queued results and clears pending.

Optional Feature:
MUL_SB_BYPASS_EN
- Defined: adds outputs id_rs1_fwd_o (1), id_rs2_fwd_o (1), id_rs1_fwd_data_o (32), id_rs2_fwd_data_o (32).
- A pending source whose value sits in a queue entry is forwarded from the youngest matching entry, with the fwd flag set. That source then does not contribute to hazard_stall_o.
- A value present only on the WMUL input that cycle is not forwarded.
- WAW hazards still stall.
- Undefined: the ports are absent and every pending source stalls.

Test Plan:
- WMUL r5=0x0000002A, WB idle, queue empty -> same cycle rf_we_o=1, addr=5, data=0x2A; pending[5] cleared next cycle.
- WB write r3=0x11 together with WMUL r7=0x22 -> cycle 0 writes r3; cycle 1 writes r7 from queue; count returns 0.
- QDEPTH=2; WB writes every cycle; WMUL results r1, r2, r4 on consecutive cycles -> mul_stall_o=1 after two pushes, r4 held; when WB goes idle, writes occur in order r1, r2, r4.
- Issue MUL to r9 from ID, then ID instruction reading rs1=r9 -> hazard_stall_o=1 until the cycle after r9 is written; deasserts exactly one cycle after the write.
- ID instruction writing rd=r9 while pending[9]=1 -> stall (WAW). Reads of r0 or WB rd=0 -> never stall or write.
- MUL_SB_BYPASS_EN defined: r9 result queued behind WB, ID reads r9 -> id_rs1_fwd_o=1 with the queued data, and hazard_stall_o=0.
- Mid-queue reset -> next cycle count=0, rf_we_o=0, pending all 0.

Source files
------------

// File: rtl/mul_wb_scheduler.sv
// -----------------------------------------------------------------------------
// mul_wb_scheduler
//
// This block shares the single regfile write port between two sources: the main
// pipeline WB stage and the output of the 5-stage MUL pipeline (WMUL). A MUL
// result that loses arbitration to WB is buffered in a small circular FIFO.
// A scoreboard records which destinations have a MUL in flight. From it the
// block raises the ID-stage RAW/WAW hazard stall.
//
// Arbitration priority on the write port:
//   1. WB write.
//   2. Head of the MUL queue.
//   3. WMUL direct, used only while the queue is empty.
// Because the direct path is only taken with an empty queue, MUL results always
// retire in issue order.
//
// Optional build macro:
//   MUL_SB_BYPASS_EN  Forwards a pending source operand from the youngest queue
//                     entry that matches it. A forwarded source no longer
//                     stalls ID.
//
// Ports:
//   clk_i, reset_i              clock, synchronous active-low reset
//   wb_valid_i/we_i/rd_i/data_i WB stage write request
//   wmul_valid_i/rd_i/data_i    MUL pipeline result at WMUL
//   id_*                        ID-stage instruction decode info
//   rf_we_o/wr_addr_o/wr_data_o regfile write port
//   mul_stall_o                 queue full: hold all MUL_M* stage registers
//   hazard_stall_o              stall PC/ID on a pending MUL destination
//   id_rs{1,2}_fwd_o, id_rs{1,2}_fwd_data_o   (MUL_SB_BYPASS_EN only)
// -----------------------------------------------------------------------------
module mul_wb_scheduler #(
    parameter int QDEPTH = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wb_valid_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    input  logic        wmul_valid_i,
    input  logic [4:0]  wmul_rd_i,
    input  logic [31:0] wmul_data_i,
    input  logic        id_valid_i,
    input  logic        id_advance_i,
    input  logic        id_is_mul_i,
    input  logic        id_reads_rs1_i,
    input  logic        id_reads_rs2_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_writes_rd_i,
    input  logic [4:0]  id_rd_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_wr_addr_o,
    output logic [31:0] rf_wr_data_o,
    output logic        mul_stall_o,
    output logic        hazard_stall_o
`ifdef MUL_SB_BYPASS_EN
    ,
    output logic        id_rs1_fwd_o,
    output logic        id_rs2_fwd_o,
    output logic [31:0] id_rs1_fwd_data_o,
    output logic [31:0] id_rs2_fwd_data_o
`endif
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    // ---------------------------------------------------------------- state
    logic [31:0]      pending_reg;
    logic [31:0]      pending_next;
    logic [4:0]       q_rd_reg   [QDEPTH];
    logic [31:0]      q_data_reg [QDEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------------------------------------------------- arbitration
    logic q_full;
    logic q_empty;
    logic wb_req;
    logic mul_in;
    logic mul_keep;   // accepted WMUL result that must reach the regfile
    logic q_pop;
    logic q_push;
    logic mul_direct;

    assign q_full  = (count_reg == CNT_W'(QDEPTH));
    assign q_empty = (count_reg == '0);
    assign wb_req  = wb_valid_i & wb_we_i & (wb_rd_i != 5'd0);
    // While the queue is full, the MUL pipeline is frozen and WMUL is not consumed.
    assign mul_in  = wmul_valid_i & ~q_full;
    // A result for r0 is accepted, so the pipeline drains, and then thrown away.
    assign mul_keep   = mul_in & (wmul_rd_i != 5'd0);
    assign q_pop      = ~wb_req & ~q_empty;
    assign mul_direct = mul_keep & ~wb_req & q_empty;
    assign q_push     = mul_keep & (wb_req | ~q_empty);

    logic        port_we;
    logic [4:0]  port_addr;
    logic [31:0] port_data;
    logic        mul_wr;      // port carries a MUL result this cycle
    logic [4:0]  mul_wr_rd;

    always_comb begin
        port_we   = 1'b0;
        port_addr = 5'd0;
        port_data = 32'd0;
        mul_wr    = 1'b0;
        mul_wr_rd = 5'd0;
        if (wb_req) begin
            port_we   = 1'b1;
            port_addr = wb_rd_i;
            port_data = wb_data_i;
        end else if (q_pop) begin
            port_we   = 1'b1;
            port_addr = q_rd_reg[rd_ptr_reg];
            port_data = q_data_reg[rd_ptr_reg];
            mul_wr    = 1'b1;
            mul_wr_rd = q_rd_reg[rd_ptr_reg];
        end else if (mul_direct) begin
            port_we   = 1'b1;
            port_addr = wmul_rd_i;
            port_data = wmul_data_i;
            mul_wr    = 1'b1;
            mul_wr_rd = wmul_rd_i;
        end
    end

    // Outputs are forced quiet while reset is held.
    assign rf_we_o      = reset_i & port_we;
    assign rf_wr_addr_o = port_addr;
    assign rf_wr_data_o = port_data;
    assign mul_stall_o  = reset_i & q_full;

    // ---------------------------------------------------------------- queue
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (q_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (q_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({q_push, q_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // The payload needs no reset. The count and the pointers decide which
    // entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (q_push) begin
            q_rd_reg[wr_ptr_reg]   <= wmul_rd_i;
            q_data_reg[wr_ptr_reg] <= wmul_data_i;
        end
    end

    // ----------------------------------------------------------- scoreboard
    logic mul_issue;
    assign mul_issue = id_valid_i & id_advance_i & id_is_mul_i & id_writes_rd_i
                       & (id_rd_i != 5'd0);

    for (genvar gi = 0; gi < 32; gi++) begin : g_sb
        // If a set and a clear hit the same register in one cycle, the set
        // wins, because the newly issued MUL is still outstanding.
        always_comb begin
            pending_next[gi] = pending_reg[gi];
            if (mul_wr && (mul_wr_rd == 5'(gi))) begin
                pending_next[gi] = 1'b0;
            end
            if (mul_issue && (id_rd_i == 5'(gi))) begin
                pending_next[gi] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            pending_reg <= 32'd0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    // --------------------------------------------------------------- hazard
    logic [1:0]       src_reads;
    logic [1:0][4:0]  src_rs;
    logic [1:0]       src_pend;  // source reads a register with a MUL in flight
    logic [1:0]       src_fwd;   // that source is covered by a queue entry
    logic             waw_hit;

    assign src_reads = {id_reads_rs2_i, id_reads_rs1_i};
    assign src_rs    = {id_rs2_i, id_rs1_i};
    assign waw_hit   = id_writes_rd_i & (id_rd_i != 5'd0) & pending_reg[id_rd_i];

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign src_pend[gi] = src_reads[gi] & (src_rs[gi] != 5'd0)
                              & pending_reg[src_rs[gi]];
    end

`ifdef MUL_SB_BYPASS_EN
    logic [1:0]        src_hit;
    logic [1:0][31:0]  src_data;

    // Walk the queue from oldest to youngest, so that the last match, which is
    // the youngest entry, determines the forwarded value.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        always_comb begin
            src_hit[gi]  = 1'b0;
            src_data[gi] = 32'd0;
            for (int k = 0; k < QDEPTH; k++) begin
                int idx;
                idx = int'(rd_ptr_reg) + k;
                if (idx >= QDEPTH) begin
                    idx = idx - QDEPTH;
                end
                if ((k < int'(count_reg)) && (q_rd_reg[idx[PTR_W-1:0]] == src_rs[gi])) begin
                    src_hit[gi]  = 1'b1;
                    src_data[gi] = q_data_reg[idx[PTR_W-1:0]];
                end
            end
        end
        assign src_fwd[gi] = src_pend[gi] & src_hit[gi];
    end

    assign id_rs1_fwd_o      = reset_i & id_valid_i & src_fwd[0];
    assign id_rs2_fwd_o      = reset_i & id_valid_i & src_fwd[1];
    assign id_rs1_fwd_data_o = src_data[0];
    assign id_rs2_fwd_data_o = src_data[1];
`else
    assign src_fwd = 2'b00;
`endif

    // Only the registered pending state is used here. A register whose MUL
    // result is being written this cycle therefore still stalls ID for this
    // cycle.
    assign hazard_stall_o = reset_i & id_valid_i
                            & (|(src_pend & ~src_fwd) | waw_hit);

endmodule

// File: tb/tb_mul_wb_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mul_wb_scheduler
//
// Directed bench for mul_wb_scheduler with QDEPTH=2. A table of per-cycle
// records gives the inputs and the expected combinational outputs for that
// cycle. After the table comes a hand-written bypass/WAW sequence whose
// expected values depend on MUL_SB_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_mul_wb_scheduler;

    localparam bit O = 1'b0;
    localparam bit I = 1'b1;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        wb_valid_i, wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        wmul_valid_i;
    logic [4:0]  wmul_rd_i;
    logic [31:0] wmul_data_i;
    logic        id_valid_i, id_advance_i, id_is_mul_i;
    logic        id_reads_rs1_i, id_reads_rs2_i;
    logic [4:0]  id_rs1_i, id_rs2_i;
    logic        id_writes_rd_i;
    logic [4:0]  id_rd_i;
    logic        rf_we_o;
    logic [4:0]  rf_wr_addr_o;
    logic [31:0] rf_wr_data_o;
    logic        mul_stall_o;
    logic        hazard_stall_o;
`ifdef MUL_SB_BYPASS_EN
    logic        id_rs1_fwd_o, id_rs2_fwd_o;
    logic [31:0] id_rs1_fwd_data_o, id_rs2_fwd_data_o;
`endif

    always #5 clk_i = ~clk_i;

    mul_wb_scheduler #(.QDEPTH(2)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .wb_valid_i     (wb_valid_i),
        .wb_we_i        (wb_we_i),
        .wb_rd_i        (wb_rd_i),
        .wb_data_i      (wb_data_i),
        .wmul_valid_i   (wmul_valid_i),
        .wmul_rd_i      (wmul_rd_i),
        .wmul_data_i    (wmul_data_i),
        .id_valid_i     (id_valid_i),
        .id_advance_i   (id_advance_i),
        .id_is_mul_i    (id_is_mul_i),
        .id_reads_rs1_i (id_reads_rs1_i),
        .id_reads_rs2_i (id_reads_rs2_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_writes_rd_i (id_writes_rd_i),
        .id_rd_i        (id_rd_i),
        .rf_we_o        (rf_we_o),
        .rf_wr_addr_o   (rf_wr_addr_o),
        .rf_wr_data_o   (rf_wr_data_o),
        .mul_stall_o    (mul_stall_o),
        .hazard_stall_o (hazard_stall_o)
`ifdef MUL_SB_BYPASS_EN
        ,
        .id_rs1_fwd_o      (id_rs1_fwd_o),
        .id_rs2_fwd_o      (id_rs2_fwd_o),
        .id_rs1_fwd_data_o (id_rs1_fwd_data_o),
        .id_rs2_fwd_data_o (id_rs2_fwd_data_o)
`endif
    );

    typedef struct {
        logic        rst_n;
        logic        wb_v;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_d;
        logic        wm_v;
        logic [4:0]  wm_rd;
        logic [31:0] wm_d;
        logic        id_v;
        logic        id_adv;
        logic        id_mul;
        logic        rd1;
        logic [4:0]  rs1;
        logic        rd2;
        logic [4:0]  rs2;
        logic        id_wr;
        logic [4:0]  id_rd;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_mst;
        logic        e_hst;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_cmp  = 0;

    task automatic add(input vec_t v);
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        reset_i        = v.rst_n;
        wb_valid_i     = v.wb_v;
        wb_we_i        = v.wb_we;
        wb_rd_i        = v.wb_rd;
        wb_data_i      = v.wb_d;
        wmul_valid_i   = v.wm_v;
        wmul_rd_i      = v.wm_rd;
        wmul_data_i    = v.wm_d;
        id_valid_i     = v.id_v;
        id_advance_i   = v.id_adv;
        id_is_mul_i    = v.id_mul;
        id_reads_rs1_i = v.rd1;
        id_rs1_i       = v.rs1;
        id_reads_rs2_i = v.rd2;
        id_rs2_i       = v.rs2;
        id_writes_rd_i = v.id_wr;
        id_rd_i        = v.id_rd;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        cmp({tag, "_we"}, 32'(rf_we_o), 32'(v.e_we));
        if (v.e_we) begin
            cmp({tag, "_addr"}, 32'(rf_wr_addr_o), 32'(v.e_addr));
            cmp({tag, "_data"}, rf_wr_data_o, v.e_data);
        end
        cmp({tag, "_mstall"}, 32'(mul_stall_o), 32'(v.e_mst));
        cmp({tag, "_hstall"}, 32'(hazard_stall_o), 32'(v.e_hst));
        $display("%s: we=%0b addr=%0d data=0x%08h mstall=%0b hstall=%0b", tag,
                 rf_we_o, rf_wr_addr_o, rf_wr_data_o, mul_stall_o, hazard_stall_o);
    endtask

    vec_t h;
    logic hst_q;   // stall expected once r9 sits in the queue

    initial begin
        // Columns: rst | wb v we rd data | wm v rd data | id v adv mul r1 rs1 r2 rs2 wr rd
        //          | exp we addr data mstall hstall
        // 0-1: reset held; WMUL and ID activity must not show on the outputs
        add('{O, O,O,5'd0,32'h0,     I,5'd5,32'h2A,   I,O,O,I,5'd5,O,5'd0,O,5'd0,    O,5'd0,32'h0,O,O});
        add('{O, O,O,5'd0,32'h0,     O,5'd0,32'h0,    O,O,O,O,5'd0,O,5'd0,O,5'd0,    O,5'd0,32'h0,O,O});
        // 2-4: issue MUL r5; direct WMUL write; pending[5] gone next cycle
        add('{I, O,O,5'd0,32'h0,     O,5'd0,32'h0,    I,I,I,O,5'd0,O,5'd0,I,5'd5,    O,5'd0,32'h0,O,O});
        add('{I, O,O,5'd0,32'h0,     I,5'd5,32'h2A,   I,O,O,I,5'd5,O,5'd0,O,5'd0,    I,5'd5,32'h2A,O,I});
        add('{I, O,O,5'd0,32'h0,     O,5'd0,32'h0,    I,O,O,I,5'd5,O,5'd0,O,5'd0,    O,5'd0,32'h0,O,O});
        // 5-7: WB r3 beats WMUL r7; r7 written from queue next cycle
        add('{I, I,I,5'd3,32'h11,    I,5'd7,32'h22,   O,O,O,O,5'd0,O,5'd0,O,5'd0,    I,5'd3,32'h11,O,O});
        add('{I, O,O,5'd0,32'h0,     O,5'd0,32'h0,    O,O,O,O,5'd0,O,5'd0,O,5'd0,    I,5'd7,32'h22,O,O});
        add('{I, O,O,5'd0,32'h0,     O,5'd0,32'h0,    O,O,O,O,5'd0,O,5'd0,O,5'd0,    O,5'd0,32'h0,O,O});
        // 8-15: WB busy, r1/r2 queued, r4 held by mul_stall, drain in order
        add('{I, I,I,5'd10,32'hA0,   I,5'd1,32'h101,  O,O,O,O,5'd0,O,5'd0,O,5'd0,    I,5'd10,32'hA0,O,O});
        add('{I, I,I,5'd11,32'hA1,   I,5'd2,32'h102,  O,O,O,O,5'd0,O,5'd0,O,5'd0,    I,5'd11,32'hA1,O,O});
        add('{I, I,I,5'd12,32'hA2,   I,5'd4,32'h104,  O,O,O,O,5'd0,O,5'd0,O,5'd0,    I,5'd12,32'hA2,I,O});
        add('{I, I,I,5'd13,32'hA3,   I,5'd4,32'h104,  O,O,O,O,5'd0,O,5'd0,O,5'd0,    I,5'd13,32'hA3,I,O});
        add('{I, O,O,5'd0,32'h0,     I,5'd4,32'h104,  O,O,O,O,5'd0,O,5'd0,O,5'd0,    I,5'd1,32'h101,I,O});
        add('{I, O,O,5'd0,32'h0,     I,5'd4,32'h104,  O,O,O,O,5'd0,O,5'd0,O,5'd0,    I,5'd2,32'h102,O,O});
        add('{I, O,O,5'd0,32'h0,     O,5'd0,32'h0,    O,O,O,O,5'd0,O,5'd0,O,5'd0,    I,5'd4,32'h104,O,O});
        add('{I, O,O,5'd0,32'h0,     O,5'd0,32'h0,    O,O,O,O,5'd0,O,5'd0,O,5'd0,    O,5'd0,32'h0,O,O});
        // 16-20: RAW on r9, WAW on r9, stall drops one cycle after the write
        add('{I, O,O,5'd0,32'h0,     O,5'd0,32'h0,    I,I,I,O,5'd0,O,5'd0,I,5'd9,    O,5'd0,32'h0,O,O});
        add('{I, O,O,5'd0,32'h0,     O,5'd0,32'h0,    I,O,O,I,5'd9,O,5'd0,O,5'd0,    O,5'd0,32'h0,O,I});
        add('{I, I,I,5'd3,32'h33,    I,5'd9,32'h99,   I,O,O,I,5'd9,O,5'd0,O,5'd0,    I,5'd3,32'h33,O,I});
        add('{I, O,O,5'd0,32'h0,     O,5'd0,32'h0,    I,O,O,O,5'd0,O,5'd0,I,5'd9,    I,5'd9,32'h99,O,I});
        add('{I, O,O,5'd0,32'h0,     O,5'd0,32'h0,    I,O,O,I,5'd9,O,5'd0,O,5'd0,    O,5'd0,32'h0,O,O});
        // 21-24: r0 cases, WMUL rd=0 dropped, WB valid without we
        add('{I, I,I,5'd0,32'hDEAD,  O,5'd0,32'h0,    I,O,O,I,5'd0,I,5'd0,I,5'd0,    O,5'd0,32'h0,O,O});
        add('{I, I,I,5'd6,32'h66,    I,5'd0,32'h77,   O,O,O,O,5'd0,O,5'd0,O,5'd0,    I,5'd6,32'h66,O,O});
        add('{I, O,O,5'd0,32'h0,     O,5'd0,32'h0,    O,O,O,O,5'd0,O,5'd0,O,5'd0,    O,5'd0,32'h0,O,O});
        add('{I, I,O,5'd8,32'h55,    O,5'd0,32'h0,    O,O,O,O,5'd0,O,5'd0,O,5'd0,    O,5'd0,32'h0,O,O});
        // 25-27: rs2 hazard, and rs2 match not read -> no stall
        add('{I, O,O,5'd0,32'h0,     O,5'd0,32'h0,    I,I,I,O,5'd0,O,5'd0,I,5'd20,   O,5'd0,32'h0,O,O});
        add('{I, O,O,5'd0,32'h0,     O,5'd0,32'h0,    I,O,O,O,5'd0,I,5'd20,O,5'd0,   O,5'd0,32'h0,O,I});
        add('{I, O,O,5'd0,32'h0,     O,5'd0,32'h0,    I,O,O,O,5'd0,O,5'd20,O,5'd0,   O,5'd0,32'h0,O,O});
        // 28-30: r20 queued, reset mid-queue discards it and clears pending
        add('{I, I,I,5'd3,32'h1,     I,5'd20,32'h2020,I,O,O,O,5'd0,I,5'd20,O,5'd0,   I,5'd3,32'h1,O,I});
        add('{O, O,O,5'd0,32'h0,     O,5'd0,32'h0,    I,O,O,O,5'd0,I,5'd20,O,5'd0,   O,5'd0,32'h0,O,O});
        add('{I, O,O,5'd0,32'h0,     O,5'd0,32'h0,    I,O,O,O,5'd0,I,5'd20,O,5'd0,   O,5'd0,32'h0,O,O});

        #1;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            #2;
            check_vec($sformatf("v%0d", i), vecs[i]);
            n_vec++;
            @(posedge clk_i);
            #1;
        end

        // Hand sequence: r9 queued behind WB while ID reads it, then WAW with it queued.
`ifdef MUL_SB_BYPASS_EN
        hst_q = 1'b0;
`else
        hst_q = 1'b1;
`endif
        // h0: issue MUL r9
        h = '{I, O,O,5'd0,32'h0, O,5'd0,32'h0, I,I,I,O,5'd0,O,5'd0,I,5'd9, O,5'd0,32'h0,O,O};
        drive(h); #2; check_vec("h0", h); n_vec++; @(posedge clk_i); #1;
        // h1: WB r3 wins, r9 only on WMUL -> not forwardable, stalls
        h = '{I, I,I,5'd3,32'h3, I,5'd9,32'hCAFE, I,O,O,I,5'd9,I,5'd9,O,5'd0, I,5'd3,32'h3,O,I};
        drive(h); #2; check_vec("h1", h);
`ifdef MUL_SB_BYPASS_EN
        cmp("h1_fwd1", 32'(id_rs1_fwd_o), 32'd0);
`endif
        n_vec++; @(posedge clk_i); #1;
        // h2: WB r4 busy, r9 sits in the queue; both sources read r9
        h = '{I, I,I,5'd4,32'h4, O,5'd0,32'h0, I,O,O,I,5'd9,I,5'd9,O,5'd0, I,5'd4,32'h4,O,hst_q};
        drive(h); #2; check_vec("h2", h);
`ifdef MUL_SB_BYPASS_EN
        cmp("h2_fwd1", 32'(id_rs1_fwd_o), 32'd1);
        cmp("h2_fwd2", 32'(id_rs2_fwd_o), 32'd1);
        cmp("h2_fwd1_data", id_rs1_fwd_data_o, 32'hCAFE);
        cmp("h2_fwd2_data", id_rs2_fwd_data_o, 32'hCAFE);
`endif
        n_vec++; @(posedge clk_i); #1;
        // h3: WB idle, r9 popped; ID also writes r9 -> WAW stall in every build
        h = '{I, O,O,5'd0,32'h0, O,5'd0,32'h0, I,O,O,I,5'd9,I,5'd9,I,5'd9, I,5'd9,32'hCAFE,O,I};
        drive(h); #2; check_vec("h3", h);
`ifdef MUL_SB_BYPASS_EN
        cmp("h3_fwd1", 32'(id_rs1_fwd_o), 32'd1);
`endif
        n_vec++; @(posedge clk_i); #1;
        // h4: r9 retired; no stall, nothing forwarded
        h = '{I, O,O,5'd0,32'h0, O,5'd0,32'h0, I,O,O,I,5'd9,I,5'd9,I,5'd9, O,5'd0,32'h0,O,O};
        drive(h); #2; check_vec("h4", h);
`ifdef MUL_SB_BYPASS_EN
        cmp("h4_fwd1", 32'(id_rs1_fwd_o), 32'd0);
`endif
        n_vec++; @(posedge clk_i); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
